// File: rtl/dmux16_stream.sv
// 1-to-2 stream demultiplexer: each accepted word is steered by in_sel into
// one of two independent FIFOs, so a stalled consumer blocks only its own traffic.
module dmux16_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         a_data,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [WIDTH-1:0]         b_data,
  output logic                     b_valid,
  input  logic                     b_ready,
  output logic [$clog2(DEPTH):0]   a_count,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef logic [PtrW-1:0]  ptr_t;
  typedef logic [CntW-1:0]  cnt_t;
  typedef logic [WIDTH-1:0] word_t;

  word_t a_mem_q [DEPTH];
  word_t a_mem_d [DEPTH];
  word_t b_mem_q [DEPTH];
  word_t b_mem_d [DEPTH];

  ptr_t a_wr_ptr_q, a_wr_ptr_d, a_rd_ptr_q, a_rd_ptr_d;
  ptr_t b_wr_ptr_q, b_wr_ptr_d, b_rd_ptr_q, b_rd_ptr_d;
  cnt_t a_count_q, a_count_d;
  cnt_t b_count_q, b_count_d;

  logic a_full, b_full;
  logic a_push, b_push;
  logic a_pop, b_pop;

  // Full is judged on current occupancy only; a same-cycle pop does not free a slot.
  assign a_full   = (a_count_q == cnt_t'(DEPTH));
  assign b_full   = (b_count_q == cnt_t'(DEPTH));
  assign in_ready = in_sel ? !b_full : !a_full;

  assign a_push = in_valid && in_ready && !in_sel;
  assign b_push = in_valid && in_ready &&  in_sel;

  assign a_valid = (a_count_q != '0);
  assign b_valid = (b_count_q != '0);

  // Pop needs a stored word, so an empty FIFO never passes a push straight through.
  assign a_pop = a_valid && a_ready;
  assign b_pop = b_valid && b_ready;

  assign a_data  = a_valid ? a_mem_q[a_rd_ptr_q] : '0;
  assign b_data  = b_valid ? b_mem_q[b_rd_ptr_q] : '0;
  assign a_count = a_count_q;
  assign b_count = b_count_q;

  always_comb begin
    a_mem_d    = a_mem_q;
    a_wr_ptr_d = a_wr_ptr_q;
    a_rd_ptr_d = a_rd_ptr_q;
    if (a_push) begin
      a_mem_d[a_wr_ptr_q] = in_data;
      a_wr_ptr_d          = a_wr_ptr_q + ptr_t'(1);
    end
    if (a_pop) begin
      a_rd_ptr_d = a_rd_ptr_q + ptr_t'(1);
    end
    a_count_d = a_count_q + cnt_t'(a_push) - cnt_t'(a_pop);
  end

  always_comb begin
    b_mem_d    = b_mem_q;
    b_wr_ptr_d = b_wr_ptr_q;
    b_rd_ptr_d = b_rd_ptr_q;
    if (b_push) begin
      b_mem_d[b_wr_ptr_q] = in_data;
      b_wr_ptr_d          = b_wr_ptr_q + ptr_t'(1);
    end
    if (b_pop) begin
      b_rd_ptr_d = b_rd_ptr_q + ptr_t'(1);
    end
    b_count_d = b_count_q + cnt_t'(b_push) - cnt_t'(b_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
      a_wr_ptr_q <= '0;
      a_rd_ptr_q <= '0;
      a_count_q  <= '0;
      b_wr_ptr_q <= '0;
      b_rd_ptr_q <= '0;
      b_count_q  <= '0;
    end else begin
      a_mem_q    <= a_mem_d;
      b_mem_q    <= b_mem_d;
      a_wr_ptr_q <= a_wr_ptr_d;
      a_rd_ptr_q <= a_rd_ptr_d;
      a_count_q  <= a_count_d;
      b_wr_ptr_q <= b_wr_ptr_d;
      b_rd_ptr_q <= b_rd_ptr_d;
      b_count_q  <= b_count_d;
    end
  end

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed bench for dmux16_stream: reset, steering, back-pressure, wrap,
// concurrent push/pop and mid-stream reset.
module tb_dmux16_stream;

  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [2:0]  a_count;
  logic [2:0]  b_count;

  int passed = 0;
  int total  = 0;

  dmux16_stream #(.WIDTH(16), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int sent;
    int rcvd;
    logic push_now;
    logic pop_now;

    // Reset held with traffic offered: nothing may be accepted.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h5555;
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    tick();
    tick();
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_a_data",  32'(a_data),  32'd0);
    check("rst_b_data",  32'(b_data),  32'd0);
    check("rst_a_count", 32'(a_count), 32'd0);
    check("rst_b_count", 32'(b_count), 32'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic steering.
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h1234;
    #1;
    check("steer_no_passthru", 32'(a_valid), 32'd0);
    tick();
    check("steer_a_valid", 32'(a_valid), 32'd1);
    check("steer_a_data",  32'(a_data),  32'h1234);
    check("steer_b_quiet", 32'(b_valid), 32'd0);
    in_sel  = 1'b1;
    in_data = 16'hABCD;
    tick();
    check("steer_a_gone",  32'(a_valid), 32'd0);
    check("steer_a_zero",  32'(a_data),  32'd0);
    check("steer_b_valid", 32'(b_valid), 32'd1);
    check("steer_b_data",  32'(b_data),  32'hABCD);
    in_valid = 1'b0;
    tick();
    check("steer_b_gone",  32'(b_valid), 32'd0);

    // Fill A under back-pressure.
    a_ready  = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_data = 16'(i);
      #1;
      check("fill_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_data = 16'h0005;
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_a_count",  32'(a_count),  32'd4);
    tick();
    check("stall_a_count", 32'(a_count),  32'd4);
    check("stall_a_head",  32'(a_data),   32'h0001);
    in_sel = 1'b1;
    #1;
    check("resel_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("resel_b_valid", 32'(b_valid), 32'd1);
    check("resel_b_data",  32'(b_data),  32'h0005);
    check("resel_b_count", 32'(b_count), 32'd1);
    check("resel_a_count", 32'(a_count), 32'd4);
    a_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("drain_a_data", 32'(a_data), 32'(i));
      tick();
    end
    check("drain_a_empty", 32'(a_valid), 32'd0);
    check("drain_b_empty", 32'(b_valid), 32'd0);

    // Wrap-around with a_ready toggling.
    sent   = 0;
    rcvd   = 0;
    in_sel = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_ready  = cyc[0];
      in_valid = (sent < 10);
      in_data  = 16'h0100 + 16'(sent);
      #1;
      push_now = in_valid && in_ready;
      pop_now  = a_valid && a_ready;
      if (pop_now) begin
        check("wrap_order", 32'(a_data), 32'h0100 + 32'(rcvd));
        rcvd++;
      end
      check("wrap_count_max", 32'(a_count <= 3'd4), 32'd1);
      if (push_now) sent++;
      tick();
      if (sent == 10 && rcvd == 10) break;
    end
    in_valid = 1'b0;
    check("wrap_sent", 32'(sent), 32'd10);
    check("wrap_rcvd", 32'(rcvd), 32'd10);
    check("wrap_empty", 32'(a_valid), 32'd0);

    // Concurrent push and pop on A at count 2.
    a_ready  = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h0200;
    tick();
    in_data  = 16'h0201;
    tick();
    a_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'h0202 + 16'(i);
      #1;
      check("pp_count", 32'(a_count), 32'd2);
      check("pp_head",  32'(a_data),  32'h0200 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("pp_count_end", 32'(a_count), 32'd2);
    check("pp_tail0", 32'(a_data), 32'h0208);
    tick();
    check("pp_tail1", 32'(a_data), 32'h0209);
    tick();
    check("pp_empty", 32'(a_valid), 32'd0);

    // Mid-stream reset discards both FIFOs.
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_sel  = (i >= 3);
      in_data = (i < 3) ? 16'h0300 + 16'(i) : 16'h0400 + 16'(i - 3);
      tick();
    end
    in_valid = 1'b0;
    check("mid_a_count", 32'(a_count), 32'd3);
    check("mid_b_count", 32'(b_count), 32'd2);
    check("mid_b_head",  32'(b_data),  32'h0400);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_a_valid", 32'(a_valid), 32'd0);
    check("mrst_b_valid", 32'(b_valid), 32'd0);
    check("mrst_a_count", 32'(a_count), 32'd0);
    check("mrst_b_count", 32'(b_count), 32'd0);
    check("mrst_b_data",  32'(b_data),  32'd0);
    in_valid = 1'b1;
    in_sel   = 1'b1;
    in_data  = 16'hBEEF;
    tick();
    in_valid = 1'b0;
    check("post_b_data",  32'(b_data),  32'hBEEF);
    check("post_b_count", 32'(b_count), 32'd1);
    check("post_a_valid", 32'(a_valid), 32'd0);
    b_ready = 1'b1;
    tick();
    check("post_b_alone", 32'(b_valid), 32'd0);
    check("post_b_zero",  32'(b_data),  32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmux16_stream.md
Name: dmux16_stream

Overview:
- 1-to-2 demultiplexer for a 16-bit word stream. Sits between a single producer, such as the CPU write path, and two consumers, such as RAM-side and I/O-side sinks.
- Steers each accepted word to output A or B according to a per-word select bit. Each output has its own FIFO, so a stalled consumer only blocks words addressed to it.
- Valid/ready handshake on all three ports.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 4, entries per output FIFO; must be a power of 2 and >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  word offered by the producer.
- in_sel  input  1  destination of in_data: 0 = output A, 1 = output B.
- in_valid  input  1  producer has a word on in_data/in_sel.
- in_ready  output  1  block can accept the offered word this cycle.
- a_data  output  WIDTH  head word of the A FIFO.
- a_valid  output  1  A FIFO non-empty.
- a_ready  input  1  consumer A accepts a_data this cycle.
- b_data  output  WIDTH  head word of the B FIFO.
- b_valid  output  1  B FIFO non-empty.
- b_ready  input  1  consumer B accepts b_data this cycle.
- a_count  output  $clog2(DEPTH)+1  A FIFO occupancy, 0..DEPTH.
- b_count  output  $clog2(DEPTH)+1  B FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (synchronous, highest priority over all other events):
  - both FIFO pointers and counts cleared to 0;
  - a_valid = b_valid = 0;
  - a_data = b_data = 0;
  - stored contents discarded, including when reset arrives mid-stream.
- in_ready is combinational:
  - equals !a_full when in_sel = 0 and !b_full when in_sel = 1;
  - may depend on in_sel and FIFO state only, not on in_valid.
- Push: a word is accepted on an edge where in_valid && in_ready. It is written at the selected FIFO's write pointer, that pointer increments modulo DEPTH, and that count increments.
- The non-selected FIFO is untouched by a push.
- Latency: a word accepted on edge N is visible on its output (valid = 1) after edge N, i.e. in cycle N+1. There is no same-cycle pass-through, even when the FIFO is empty.
- Output data and valid:
  - x_valid = (x_count != 0);
  - x_data = FIFO head when x_valid = 1, else forced to 0;
  - x_data is stable while x_valid && !x_ready.
- Pop: on an edge where x_valid && x_ready, the read pointer increments modulo DEPTH and x_count decrements.
- x_ready while x_valid = 0 has no effect: no underflow and no pointer movement.
- Simultaneous push and pop on the same FIFO (non-full):
  - count unchanged, both pointers advance;
  - head advances to the next word, or to the newly pushed word if it was the only one.
- Full FIFO:
  - in_ready = 0 for words selected to it, even if the consumer pops in the same cycle;
  - the freed slot is offered from the next cycle.
- Empty FIFO with a push and an asserted consumer ready: pop ignored, push performed, count becomes 1.
- Wrap-around: pointers wrap from DEPTH-1 to 0; count distinguishes full from empty.
- Ordering:
  - strict FIFO order within each output;
  - no ordering relation between A and B outputs.
- Independence: A and B pops can occur on the same edge as each other and as a push to either FIFO.
- Producer contract (in_data/in_sel stable while in_valid && !in_ready) is not checked by the block.
  - A producer may change in_sel while stalled.
  - in_ready then re-evaluates against the newly selected FIFO.

Test Plan:
- Reset state: hold reset 2 cycles with in_valid = 1, a_ready = b_ready = 1 -> a_valid = b_valid = 0, a_data = b_data = 0, a_count = b_count = 0, nothing accepted.
- Basic steering: push 0x1234 sel 0, then 0xABCD sel 1, with both readys = 1 -> a_data = 0x1234 and b_data = 0xABCD, each valid for exactly 1 cycle, one cycle after its push.
- Fill and back-pressure: a_ready = 0, push 0x0001..0x0005 sel 0 -> first 4 accepted, a_count = 4, in_ready = 0 on the 5th. Switch in_sel to 1 with the same data -> in_ready = 1, word lands in B. Release a_ready -> A drains 1,2,3,4 in order.
- Wrap-around: 10 words 0x0100..0x0109 sel 0, a_ready toggling 1/0 every cycle -> all 10 emerge in order, a_count never exceeds 4, no word lost or duplicated.
- Simultaneous push/pop on the same output: keep A at count 2 while pushing and popping on the same edge for 8 cycles -> a_count stays 2 and outputs follow push order.
- Mid-operation reset: A holds 3 words and B holds 2, assert reset 1 cycle -> both valids drop next cycle, counts 0, and a subsequent push 0xBEEF sel 1 appears alone on b_data.
